// File: rtl/bin_to_sseg_scan.sv
// Binary-to-BCD (sequential double-dabble) feeding a multiplexed common-anode
// 7-segment display with leading-zero blanking and overflow dashes.

module sseg_digit_dec (
    input  logic [3:0] nib,
    input  logic       blank,
    input  logic       dash,
    output logic [0:6] seg
);
    always_comb begin
        seg = 7'b1111111;
        if (dash) begin
            seg = 7'b1111110;
        end else if (!blank) begin
            case (nib)
                4'd0:    seg = 7'b0000001;
                4'd1:    seg = 7'b1001111;
                4'd2:    seg = 7'b0010010;
                4'd3:    seg = 7'b0000110;
                4'd4:    seg = 7'b1001100;
                4'd5:    seg = 7'b0100100;
                4'd6:    seg = 7'b0100000;
                4'd7:    seg = 7'b0001111;
                4'd8:    seg = 7'b0000000;
                4'd9:    seg = 7'b0000100;
                default: seg = 7'b1111111;
            endcase
        end
    end
endmodule

module bin_to_sseg_scan #(
    parameter int WIDTH    = 8,
    parameter int DIGITS   = 3,
    parameter int SCAN_DIV = 50000,
    parameter int LZB      = 1
) (
    input  logic              clk2,
    input  logic              rst,
    input  logic [WIDTH-1:0]  num,
    input  logic              load,
    output logic              busy,
    output logic              overflow,
    output logic [0:6]        SSeg,
    output logic [DIGITS-1:0] An
);
    localparam int BW = DIGITS * 4;
    localparam int CW = $clog2(WIDTH + 1);
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int PW = $clog2(SCAN_DIV);

    function automatic logic [63:0] pow10(input int n);
        logic [63:0] r;
        r = 64'd1;
        for (int i = 0; i < n; i++) r = r * 64'd10;
        return r;
    endfunction

    localparam logic [63:0] LIMIT = pow10(DIGITS);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t            state, state_nxt;
    logic [WIDTH-1:0]  bin_r, bin_sh;
    logic [BW-1:0]     bcd, bcd_adj, bcd_sh;
    logic [CW-1:0]     cnt;
    logic              ovf_pend, ovf_chk, done;
    logic [BW-1:0]     disp, disp_nxt;
    logic              ovf_nxt;
    logic [PW-1:0]     presc, presc_nxt;
    logic [IW-1:0]     idx, idx_nxt;
    logic              tc;
    logic [DIGITS-1:0] blank;
    logic              hi_zero;
    logic [DIGITS-1:0][0:6] seg_all;

    // --- conversion FSM ---
    always_ff @(posedge clk2 or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (load) state_nxt = SHIFT;
            SHIFT:   if (cnt == CW'(1)) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == SHIFT);
        done = (state == SHIFT) && (cnt == CW'(1));
    end

    // Range check is done on the raw binary, so dropped BCD carries are still flagged.
    assign ovf_chk = ({{(64-WIDTH){1'b0}}, num} >= LIMIT);

    always_comb begin
        bcd_adj = bcd;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
        end
        bcd_sh = {bcd_adj[BW-2:0], bin_r[WIDTH-1]};
        bin_sh = {bin_r[WIDTH-2:0], 1'b0};
    end

    always_ff @(posedge clk2 or posedge rst) begin
        if (rst) begin
            bin_r    <= '0;
            bcd      <= '0;
            cnt      <= '0;
            ovf_pend <= 1'b0;
            disp     <= '0;
            overflow <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    ovf_pend <= ovf_chk;
                    if (load) begin
                        bin_r <= num;
                        bcd   <= '0;
                        cnt   <= CW'(WIDTH);
                    end
                end
                SHIFT: begin
                    bin_r <= bin_sh;
                    bcd   <= bcd_sh;
                    cnt   <= cnt - CW'(1);
                    if (done) begin
                        disp     <= bcd_sh;
                        overflow <= ovf_pend;
                    end
                end
                default: ;
            endcase
        end
    end

    // --- scan and segment output ---
    assign disp_nxt = done ? bcd_sh : disp;
    assign ovf_nxt  = done ? ovf_pend : overflow;

    always_comb begin
        tc        = (presc == PW'(SCAN_DIV - 1));
        presc_nxt = tc ? '0 : presc + PW'(1);
        idx_nxt   = idx;
        if (tc) idx_nxt = (idx == IW'(DIGITS - 1)) ? '0 : idx + IW'(1);
    end

    // Blank digit k when it and every digit above it are zero.
    always_comb begin
        blank   = '0;
        hi_zero = 1'b1;
        for (int k = DIGITS - 1; k >= 0; k--) begin
            hi_zero  = hi_zero && (disp_nxt[4*k +: 4] == 4'd0);
            blank[k] = (LZB != 0) && (k != 0) && hi_zero;
        end
    end

    for (genvar k = 0; k < DIGITS; k++) begin : g_dig
        sseg_digit_dec u_dec (
            .nib   (disp_nxt[4*k +: 4]),
            .blank (blank[k]),
            .dash  (ovf_nxt),
            .seg   (seg_all[k])
        );
    end

    // Outputs are registered from next-state values so they track idx/disp without a lag.
    always_ff @(posedge clk2 or posedge rst) begin
        if (rst) begin
            presc <= '0;
            idx   <= '0;
            SSeg  <= 7'b0000001;
            An    <= ~DIGITS'(1);
        end else begin
            presc <= presc_nxt;
            idx   <= idx_nxt;
            SSeg  <= seg_all[idx_nxt];
            An    <= ~(DIGITS'(1) << idx_nxt);
        end
    end
endmodule

// File: tb/tb_bin_to_sseg_scan.sv
// Scoreboarded bench: three instances share one stimulus stream (3-digit LZB,
// 2-digit LZB, 3-digit no-LZB); expected display derives from decimal arithmetic.

module tb_bin_to_sseg_scan;
    logic       clk2, rst, load;
    logic [7:0] num;

    logic       busy_a, ovf_a, busy_b, ovf_b, busy_c, ovf_c;
    logic [0:6] seg_a, seg_b, seg_c;
    logic [2:0] an_a, an_c;
    logic [1:0] an_b;

    bin_to_sseg_scan #(.WIDTH(8), .DIGITS(3), .SCAN_DIV(4), .LZB(1)) u_dut (
        .clk2(clk2), .rst(rst), .num(num), .load(load),
        .busy(busy_a), .overflow(ovf_a), .SSeg(seg_a), .An(an_a));
    bin_to_sseg_scan #(.WIDTH(8), .DIGITS(2), .SCAN_DIV(4), .LZB(1)) u_d2 (
        .clk2(clk2), .rst(rst), .num(num), .load(load),
        .busy(busy_b), .overflow(ovf_b), .SSeg(seg_b), .An(an_b));
    bin_to_sseg_scan #(.WIDTH(8), .DIGITS(3), .SCAN_DIV(4), .LZB(0)) u_nz (
        .clk2(clk2), .rst(rst), .num(num), .load(load),
        .busy(busy_c), .overflow(ovf_c), .SSeg(seg_c), .An(an_c));

    int total = 0;
    int bad   = 0;
    int cyc, busy_m, cur_v;
    bit prev_busy;
    int exp_q[$];

    initial begin
        clk2 = 1'b0;
        forever #5 clk2 = ~clk2;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            if (bad <= 40) $display("FAIL %s got=%0h want=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    function automatic int p10(input int n);
        int r = 1;
        for (int i = 0; i < n; i++) r = r * 10;
        return r;
    endfunction

    function automatic logic [6:0] exp_seg(input int v, input int k, input int d, input bit lzb);
        int m;
        if (v >= p10(d)) return 7'b1111110;
        m = v / p10(k);
        if (lzb && k > 0 && m == 0) return 7'b1111111;
        case (m % 10)
            0: return 7'b0000001;
            1: return 7'b1001111;
            2: return 7'b0010010;
            3: return 7'b0000110;
            4: return 7'b1001100;
            5: return 7'b0100100;
            6: return 7'b0100000;
            7: return 7'b0001111;
            8: return 7'b0000000;
            9: return 7'b0000100;
            default: return 7'b1111111;
        endcase
    endfunction

    task automatic check_inst(input string nm, input logic [6:0] seg, input logic [4:0] an,
                              input logic ovf, input logic bsy, input int d, input bit lzb);
        int idx;
        idx = (cyc / 4) % d;
        chk({nm, "_an"},   32'(an),  32'((~(1 << idx)) & ((1 << d) - 1)));
        chk({nm, "_seg"},  32'(seg), 32'(exp_seg(cur_v, idx, d, lzb)));
        chk({nm, "_ovf"},  32'(ovf), 32'(cur_v >= p10(d)));
        chk({nm, "_busy"}, 32'(bsy), 32'(busy_m > 0));
    endtask

    // Reference model: accepts a load only when no conversion is pending.
    initial begin
        cyc = 0; busy_m = 0;
        forever begin
            @(posedge clk2 or posedge rst);
            if (rst) begin
                cyc = 0; busy_m = 0;
                exp_q.delete();
            end else begin
                cyc++;
                if (busy_m > 0) busy_m--;
                else if (load) begin
                    busy_m = 8;
                    exp_q.push_back(int'(num));
                end
            end
        end
    end

    // Monitor: a falling busy means a new display value is visible.
    initial begin
        cur_v = 0; prev_busy = 1'b0;
        forever begin
            @(negedge clk2);
            if (rst) begin
                cur_v = 0; prev_busy = 1'b0;
            end else if (prev_busy && !busy_a) begin
                chk("sb_pop", 32'(exp_q.size() > 0), 32'd1);
                if (exp_q.size() > 0) cur_v = exp_q.pop_front();
            end
            check_inst("d3", seg_a, {2'b0, an_a}, ovf_a, busy_a, 3, 1'b1);
            check_inst("d2", seg_b, {3'b0, an_b}, ovf_b, busy_b, 2, 1'b1);
            check_inst("nz", seg_c, {2'b0, an_c}, ovf_c, busy_c, 3, 1'b0);
            if (!rst) prev_busy = busy_a;
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk2);
        #1;
    endtask

    task automatic do_load(input int v);
        @(posedge clk2); #1;
        num = 8'(v); load = 1'b1;
        @(posedge clk2); #1;
        load = 1'b0;
    endtask

    initial begin
        int dir [8];
        dir = '{59, 0, 9, 10, 99, 100, 42, 7};
        rst = 1'b1; load = 1'b0; num = '0;
        idle(3);
        rst = 1'b0;
        idle(14);
        foreach (dir[i]) begin
            do_load(dir[i]);
            idle(14);
        end
        do_load(255);
        idle(3);
        do_load(17);
        idle(16);
        // Reset three cycles into a conversion of 200.
        do_load(200);
        idle(2);
        rst = 1'b1;
        #1;
        chk("rst_busy", 32'(busy_a), 32'd0);
        chk("rst_seg",  32'(seg_a), 32'b0000001);
        chk("rst_an",   32'(an_a), 32'b110);
        chk("rst_ovf",  32'(ovf_a), 32'd0);
        idle(2);
        rst = 1'b0;
        do_load(200);
        idle(14);
        repeat (80) begin
            idle($urandom_range(0, 12));
            do_load($urandom_range(0, 255));
        end
        for (int i = 0; i < 60; i++) begin
            @(negedge clk2); #1;
            if (busy_m == 0 && exp_q.size() == 0) break;
        end
        chk("drain", 32'(exp_q.size()), 32'd0);
        idle(4);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
